// File: rtl/lstm_cstate_seq_if.sv
// Stream and quantizer-operand bundle for the LSTM cell-state sequencer.
// A transfer occurs on a rising edge where valid and ready are both high; valid, once raised, holds its payload stable until that edge.
interface lstm_cstate_seq_if;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         f_q;
  logic [7:0]         i_q;
  logic [7:0]         g_q;
  logic [4:0]         comb_ctrl;
  logic signed [16:0] temp_regA;
  logic [7:0]         temp_regB;
  logic [7:0]         temp_regC;
  logic [7:0]         B_sat_MAQ;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_ct;
  logic [7:0]         out_idx;
  logic               out_last;

  modport slave (
    input  in_valid, f_q, i_q, g_q, B_sat_MAQ, out_ready,
    output in_ready, comb_ctrl, temp_regA, temp_regB, temp_regC,
           out_valid, out_ct, out_idx, out_last
  );

  modport master (
    output in_valid, f_q, i_q, g_q, B_sat_MAQ, out_ready,
    input  in_ready, comb_ctrl, temp_regA, temp_regB, temp_regC,
           out_valid, out_ct, out_idx, out_last
  );
endinterface

// File: rtl/lstm_cstate_seq.sv
// Cell-state sequencer: forms the forget-gate product, drives the B-stage quantizer,
// writes the result back into the local Ct register file and streams it out.
module lstm_cstate_seq #(
  parameter int         HIDDEN           = 16,
  parameter logic [7:0] ZERO_STATE       = 8'd128,
  parameter logic [7:0] OUT_ZERO_SIGMOID = 8'd0
) (
  input  logic                clk,
  input  logic                resetn,
  lstm_cstate_seq_if.slave    bus,
  input  logic                clear,
  input  logic                st_wr_en,
  input  logic [7:0]          st_wr_addr,
  input  logic [7:0]          st_wr_data,
  output logic [1:0]          state_dbg
);
  localparam int         AW   = (HIDDEN > 1) ? $clog2(HIDDEN) : 1;
  localparam logic [7:0] LAST = 8'(HIDDEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, ISSUE = 2'd2, OUT = 2'd3} state_t;

  state_t state_q, state_d;
  logic [7:0] ct_mem [HIDDEN];
  logic [7:0] k;
  logic       clear_pend;
  logic [7:0] f_l, i_l, g_l, ct_l;
  logic signed [16:0] temp_a;
  logic [7:0] temp_b, temp_c, out_ct_q;
  logic signed [8:0]  f_off, ct_off;

  logic in_ready_c, out_valid_c, accept, ct_clear, ct_wb, pre_wr, addr_ok;
  logic [4:0] comb_ctrl_c;

  assign addr_ok = ({1'b0, st_wr_addr} < 9'(HIDDEN));
  assign f_off   = $signed({1'b0, f_l} - {1'b0, OUT_ZERO_SIGMOID});
  assign ct_off  = $signed({1'b0, ct_l} - {1'b0, ZERO_STATE});

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    comb_ctrl_c = 5'd0;
    accept      = 1'b0;
    ct_clear    = 1'b0;
    ct_wb       = 1'b0;
    pre_wr      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = !clear;
        if (clear) begin
          ct_clear = 1'b1;
        end else begin
          pre_wr = st_wr_en && addr_ok;
          if (bus.in_valid) begin
            accept  = 1'b1;
            state_d = MUL;
          end
        end
      end
      MUL:   state_d = ISSUE;
      ISSUE: begin
        comb_ctrl_c = 5'd7;
        ct_wb       = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d  = IDLE;
          // A deferred clear lands here so IDLE is entered already cleared.
          ct_clear = clear || clear_pend;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn || ct_clear) begin
      for (int i = 0; i < HIDDEN; i++) ct_mem[i] <= ZERO_STATE;
    end else if (ct_wb) begin
      ct_mem[k[AW-1:0]] <= bus.B_sat_MAQ;
    end else if (pre_wr) begin
      ct_mem[st_wr_addr[AW-1:0]] <= st_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      k          <= 8'd0;
      clear_pend <= 1'b0;
      f_l        <= 8'd0;
      i_l        <= 8'd0;
      g_l        <= 8'd0;
      ct_l       <= 8'd0;
      temp_a     <= 17'sd0;
      temp_b     <= 8'd0;
      temp_c     <= 8'd0;
      out_ct_q   <= 8'd0;
    end else begin
      if (ct_clear)                        clear_pend <= 1'b0;
      else if (clear && state_q != IDLE)   clear_pend <= 1'b1;

      if (ct_clear)                              k <= 8'd0;
      else if (state_q == OUT && bus.out_ready)  k <= (k == LAST) ? 8'd0 : k + 8'd1;

      if (accept) begin
        f_l  <= bus.f_q;
        i_l  <= bus.i_q;
        g_l  <= bus.g_q;
        ct_l <= ct_mem[k[AW-1:0]];
      end
      if (state_q == MUL) begin
        temp_a <= f_off * ct_off;
        temp_b <= i_l;
        temp_c <= g_l;
      end
      if (ct_wb) out_ct_q <= bus.B_sat_MAQ;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.comb_ctrl = comb_ctrl_c;
  assign bus.temp_regA = temp_a;
  assign bus.temp_regB = temp_b;
  assign bus.temp_regC = temp_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_ct    = out_ct_q;
  assign bus.out_idx   = k;
  assign bus.out_last  = out_valid_c && (k == LAST);
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_lstm_cstate_seq.sv
// Directed bench for lstm_cstate_seq with a behavioural B-stage quantizer on the operand bus.
module tb_lstm_cstate_seq;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic       st_wr_en = 1'b0;
  logic [7:0] st_wr_addr = 8'd0;
  logic [7:0] st_wr_data = 8'd0;
  logic [1:0] state_dbg;
  int         n_checks = 0;
  int         n_errors = 0;
  int         q_s;

  lstm_cstate_seq_if bus ();

  lstm_cstate_seq #(.HIDDEN(16), .ZERO_STATE(8'd128), .OUT_ZERO_SIGMOID(8'd0)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus.slave),
    .clear      (clear),
    .st_wr_en   (st_wr_en),
    .st_wr_addr (st_wr_addr),
    .st_wr_data (st_wr_data),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Quantizer model: Ct' = sat8(128 + A/256 + i*(g-128)/256)
  always_comb begin
    q_s = 128 + (int'(bus.temp_regA) >>> 8)
              + ((int'(bus.temp_regB) * (int'(bus.temp_regC) - 128)) >>> 8);
    if (q_s > 255) q_s = 255;
    if (q_s < 0)   q_s = 0;
    bus.B_sat_MAQ = (bus.comb_ctrl == 5'd7) ? q_s[7:0] : 8'd0;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1 chk("clear_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic preload(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    st_wr_en = 1'b1; st_wr_addr = addr; st_wr_data = data;
    @(negedge clk);
    st_wr_en = 1'b0;
  endtask

  task automatic send(input string tag, input logic [7:0] f, input logic [7:0] i, input logic [7:0] g,
                      input int exp_a, input int exp_ct, input int exp_idx, input int stall,
                      input bit clr_mul);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.f_q = f; bus.i_q = i; bus.g_q = g;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (clr_mul) clear = 1'b1;
    chk({tag, "_mul_state"}, 32'(state_dbg), 1);
    chk({tag, "_mul_valid"}, 32'(bus.out_valid), 0);
    @(negedge clk);
    clear = 1'b0;
    chk({tag, "_issue_ctrl"}, 32'(bus.comb_ctrl), 7);
    chk({tag, "_temp_a"}, 32'(bus.temp_regA), 32'(exp_a));
    chk({tag, "_temp_b"}, 32'(bus.temp_regB), 32'(i));
    chk({tag, "_temp_c"}, 32'(bus.temp_regC), 32'(g));
    @(negedge clk);
    chk({tag, "_ctrl_off"}, 32'(bus.comb_ctrl), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_out_ct"}, 32'(bus.out_ct), 32'(exp_ct));
    chk({tag, "_out_idx"}, 32'(bus.out_idx), 32'(exp_idx));
    chk({tag, "_out_last"}, 32'(bus.out_last), (exp_idx == 15) ? 1 : 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(bus.out_valid), 1);
      chk({tag, "_stall_ct"}, 32'(bus.out_ct), 32'(exp_ct));
      chk({tag, "_stall_idx"}, 32'(bus.out_idx), 32'(exp_idx));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.f_q = 8'd0; bus.i_q = 8'd0; bus.g_q = 8'd0;
    bus.out_ready = 1'b0;
    do_reset();

    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_comb_ctrl", 32'(bus.comb_ctrl), 0);
    chk("rst_temp_a", 32'(bus.temp_regA), 0);
    chk("rst_out_ct", 32'(bus.out_ct), 0);
    chk("rst_out_idx", 32'(bus.out_idx), 0);
    chk("rst_state", 32'(state_dbg), 0);

    send("t1", 8'd200, 8'd0, 8'd77, 0, 128, 0, 0, 1'b0);

    do_clear();
    preload(8'd0, 8'd192);
    preload(8'd20, 8'd7);
    send("t2", 8'd128, 8'd0, 8'd0, 8192, 160, 0, 1, 1'b0);

    do_clear();
    send("t3", 8'd0, 8'd255, 8'd255, 0, 254, 0, 0, 1'b0);
    do_clear();
    preload(8'd0, 8'd255);
    send("t3sat", 8'd255, 8'd255, 8'd255, 32385, 255, 0, 0, 1'b0);

    do_clear();
    for (int j = 0; j < 16; j++)
      send($sformatf("t4_%0d", j), 8'd0, 8'd128, 8'(128 + j), 0, 128 + j / 2, j, j % 3, 1'b0);
    send("t4wrap", 8'd0, 8'd0, 8'd0, 0, 128, 0, 0, 1'b0);

    send("t5", 8'd0, 8'd128, 8'd200, 0, 164, 1, 2, 1'b1);
    send("t5a", 8'd255, 8'd0, 8'd0, 0, 128, 0, 0, 1'b0);
    send("t5b", 8'd255, 8'd0, 8'd0, 0, 128, 1, 0, 1'b0);

    do_reset();
    preload(8'd0, 8'd200);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.f_q = 8'd255; bus.i_q = 8'd0; bus.g_q = 8'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_issue_ctrl", 32'(bus.comb_ctrl), 7);
    chk("t6_temp_a", 32'(bus.temp_regA), 18360);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("t6_out_valid", 32'(bus.out_valid), 0);
    chk("t6_comb_ctrl", 32'(bus.comb_ctrl), 0);
    chk("t6_temp_a0", 32'(bus.temp_regA), 0);
    chk("t6_out_ct", 32'(bus.out_ct), 0);
    chk("t6_in_ready", 32'(bus.in_ready), 1);
    repeat (2) begin
      @(negedge clk);
      chk("t6_no_output", 32'(bus.out_valid), 0);
    end
    send("t6post", 8'd255, 8'd0, 8'd0, 0, 128, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
